fft8_stream_ctrl: RTL and testbench
===================================

Name: fft8_stream_ctrl

Overview:
- Sequencer wrapping the 8-point Q16.16 complex FFT core (`fft`).
- Accepts a serial stream of complex samples on a valid/ready interface, assembles a frame of 8, and drives the core's parallel inputs x0..x7 (r/i).
- Waits the core's fixed latency, captures X0..X7, then streams the results out serially in natural order with backpressure.
- Isolates the combinational/pipelined core from streaming producers and consumers.

Parameters:
- DW, 32, sample word width per real/imag component (Q16.16 two's complement).
- N, 8, points per frame; fixed at 8 for this core; index width IW = 3.
- CORE_LAT, 2, clk edges from core input change to valid core output; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller can accept a sample.
- in_re  in  DW  input sample, real part.
- in_im  in  DW  input sample, imaginary part.
- core_x_re  out  N*DW  to core x0r..x7r; slice k = bits [k*DW +: DW].
- core_x_im  out  N*DW  to core x0i..x7i; same packing.
- core_X_re  in  N*DW  from core X0r..X7r; same packing.
- core_X_im  in  N*DW  from core X0i..X7i; same packing.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts bin.
- out_re  out  DW  output bin, real part.
- out_im  out  DW  output bin, imaginary part.
- out_idx  out  3  bin index 0..7.
- out_last  out  1  high with bin 7.
- busy  out  1  high in WAIT or UNLOAD.
- frame_cnt  out  16  completed frames, wraps at 65535->0.

Behaviour:
- Reset values (clk edge with rst=1):
  - state=LOAD; load index=0.
  - core_x_re/im=0; output buffer=0.
  - out_valid=0, out_re/im=0, out_idx=0, out_last=0.
  - busy=0, frame_cnt=0.
  - A reset mid-frame (any state) discards partial input and undelivered output.
- FSM: LOAD -> WAIT -> UNLOAD -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, write in_re/in_im into slot k = load index, then k++.
  - On the handshake with k=7: go to WAIT, load wait counter with CORE_LAT, reset k to 0.
  - Unwritten slots keep their previous frame's values; all 8 are overwritten before use.
- WAIT:
  - in_ready=0; core_x held stable.
  - Counter decrements each edge.
  - On the edge where counter==1: capture core_X_re/im into the output buffer, set out_idx=0, go to UNLOAD.
  - out_valid rises exactly CORE_LAT edges after the 8th input handshake edge.
- UNLOAD:
  - out_valid=1; out_re/im = buffer[out_idx]; out_last = (out_idx==7).
  - On out_valid&&out_ready: out_idx++.
  - When the accepted bin is idx 7: out_valid=0, frame_cnt++, go to LOAD; in_ready=1 the next cycle.
  - Without out_ready: out_* held stable, no timeout.
- Ordering and overlap:
  - No overlap: input is refused during WAIT/UNLOAD; throughput is one frame per 8 + CORE_LAT + 8 cycles minimum.
  - Output bins come in natural order, no reordering or scaling. Arithmetic width and overflow are owned by the core; the controller passes words bit-exact.
- Outputs are registered.
  - busy = (state != LOAD).
  - in_ready is decoded from the state register only; no combinational path from out_ready or in_valid.

Decomposition:
- Package fft8_pkg: DW, N, IW; state enum {LOAD, WAIT, UNLOAD}; Q16.16 constants ONE=32'h0001_0000, ZERO.
- One natural sub-module, fft8_frame_buf: 8-entry DW-wide re/im register file with indexed write port, flat parallel read, and indexed read mux. Instanced twice: input assembly and output buffer.
- The FSM, counters and the core instance stay in the top.

Test Plan:
- Impulse, out_ready=1: x0=ONE, x1..x7=0 -> bins 0..7 all re=32'h0001_0000, im=0; out_last only on idx 7; frame_cnt=1.
- DC: all 8 samples re=ONE, im=0 -> bin0 re=32'h0008_0000; bins 1..7 re=im=0 within ±1 LSB.
- Latency: with CORE_LAT=2, 8th handshake at edge t -> out_valid first high after edge t+2. During WAIT, in_valid held high is not accepted (in_ready=0).
- Backpressure: toggle out_ready 1,0,0,1,... during UNLOAD -> out_re/im/idx stable while stalled; 8 bins delivered exactly once, in order 0..7.
- Reset mid-LOAD after 5 samples, then a full impulse frame -> output equals the impulse result; first 5 samples ignored; frame_cnt=1.
- Back-to-back: 3 frames with in_valid always high -> in_ready low during WAIT/UNLOAD, high the cycle after bin 7 accepted; frame_cnt=3; each frame's bins match its own input.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared widths, FSM states and Q16.16 constants for the 8-point FFT stream
// controller and its frame buffers.
package fft8_pkg;

   localparam int DW = 32;
   localparam int N  = 8;
   localparam int IW = 3;

   localparam logic [DW-1:0] ONE  = 32'h0001_0000;
   localparam logic [DW-1:0] ZERO = 32'h0000_0000;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      WAIT   = 2'd1,
      UNLOAD = 2'd2
   } state_t;

   function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] flat,
                                           input logic [IW-1:0]   k);
      return flat[int'(k)*DW +: DW];
   endfunction

endpackage

// File: rtl/fft8_frame_buf.sv
// Eight-entry complex register file: indexed write or whole-frame load,
// flat parallel read and indexed read mux.
module fft8_frame_buf
   import fft8_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IW-1:0]     widx,
   input  logic [DW-1:0]     wre,
   input  logic [DW-1:0]     wim,
   input  logic              ld,
   input  logic [N*DW-1:0]   ld_re,
   input  logic [N*DW-1:0]   ld_im,
   input  logic [IW-1:0]     ridx,
   output logic [N*DW-1:0]   flat_re,
   output logic [N*DW-1:0]   flat_im,
   output logic [DW-1:0]     rd_re,
   output logic [DW-1:0]     rd_im
);

   logic [N*DW-1:0] mem_re_q, mem_re_d;
   logic [N*DW-1:0] mem_im_q, mem_im_d;

   always_comb begin
      mem_re_d = mem_re_q;
      mem_im_d = mem_im_q;
      if (ld) begin
         mem_re_d = ld_re;
         mem_im_d = ld_im;
      end else if (we) begin
         mem_re_d[int'(widx)*DW +: DW] = wre;
         mem_im_d[int'(widx)*DW +: DW] = wim;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_re_q <= '0;
         mem_im_q <= '0;
      end else begin
         mem_re_q <= mem_re_d;
         mem_im_q <= mem_im_d;
      end
   end

   assign flat_re = mem_re_q;
   assign flat_im = mem_im_q;
   assign rd_re   = slice(mem_re_q, ridx);
   assign rd_im   = slice(mem_im_q, ridx);

endmodule

// File: rtl/fft8_stream_ctrl.sv
// Streams 8 complex samples into the FFT core, waits its latency, then
// streams the 8 bins back out in natural order with backpressure.
module fft8_stream_ctrl
   import fft8_pkg::*;
#(
   parameter int CORE_LAT = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_re,
   input  logic [DW-1:0]     in_im,
   output logic [N*DW-1:0]   core_x_re,
   output logic [N*DW-1:0]   core_x_im,
   input  logic [N*DW-1:0]   core_X_re,
   input  logic [N*DW-1:0]   core_X_im,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_re,
   output logic [DW-1:0]     out_im,
   output logic [IW-1:0]     out_idx,
   output logic              out_last,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   state_t          state_q, state_d;
   logic [IW-1:0]   k_q, k_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            out_valid_q, out_valid_d;
   logic [IW-1:0]   out_idx_q, out_idx_d;
   logic            out_last_q, out_last_d;
   logic [DW-1:0]   out_re_q, out_re_d;
   logic [DW-1:0]   out_im_q, out_im_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic            cap;
   logic            in_fire, out_fire;
   logic [IW-1:0]   ob_ridx;
   logic [DW-1:0]   ob_rd_re, ob_rd_im;

   assign in_ready = (state_q == LOAD);
   assign busy     = (state_q != LOAD);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;
   assign ob_ridx  = out_idx_q + 3'd1;

   fft8_frame_buf u_in_buf (
      .clk     (clk),
      .rst     (rst),
      .we      (in_fire),
      .widx    (k_q),
      .wre     (in_re),
      .wim     (in_im),
      .ld      (1'b0),
      .ld_re   ('0),
      .ld_im   ('0),
      .ridx    ('0),
      .flat_re (core_x_re),
      .flat_im (core_x_im),
      .rd_re   (),
      .rd_im   ()
   );

   fft8_frame_buf u_out_buf (
      .clk     (clk),
      .rst     (rst),
      .we      (1'b0),
      .widx    ('0),
      .wre     ('0),
      .wim     ('0),
      .ld      (cap),
      .ld_re   (core_X_re),
      .ld_im   (core_X_im),
      .ridx    (ob_ridx),
      .flat_re (),
      .flat_im (),
      .rd_re   (ob_rd_re),
      .rd_im   (ob_rd_im)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:    if (in_fire && k_q == 3'd7) state_d = WAIT;
         WAIT:    if (cnt_q == 4'd1) state_d = UNLOAD;
         UNLOAD:  if (out_fire && out_idx_q == 3'd7) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      k_d         = k_q;
      cnt_d       = cnt_q;
      cap         = 1'b0;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         LOAD: begin
            if (in_fire) begin
               k_d = k_q + 3'd1;
               if (k_q == 3'd7) cnt_d = 4'(CORE_LAT);
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               // Bin 0 comes straight from the core; the buffer fills this edge.
               cap         = 1'b1;
               out_valid_d = 1'b1;
               out_idx_d   = '0;
               out_last_d  = 1'b0;
               out_re_d    = slice(core_X_re, '0);
               out_im_d    = slice(core_X_im, '0);
            end
         end
         UNLOAD: begin
            if (out_fire) begin
               out_idx_d  = ob_ridx;
               out_re_d   = ob_rd_re;
               out_im_d   = ob_rd_im;
               out_last_d = (out_idx_q == 3'd6);
               if (out_idx_q == 3'd7) begin
                  out_valid_d = 1'b0;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q         <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         frame_cnt_q <= '0;
      end else begin
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft8_stream_ctrl.sv
// Bench for fft8_stream_ctrl with a behavioural 8-point DFT standing in
// for the core (one register stage, i.e. two edges input-to-capture).
module tb_fft8_stream_ctrl;
   import fft8_pkg::*;

   localparam logic [31:0] C    = 32'h0000_B505;
   localparam logic [31:0] NC   = 32'hFFFF_4AFB;
   localparam logic [31:0] NONE = 32'hFFFF_0000;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready;
   logic [31:0]     in_re, in_im;
   logic [255:0]    core_x_re, core_x_im;
   logic [255:0]    core_X_re, core_X_im;
   logic [255:0]    dft_re, dft_im;
   logic            out_valid, out_ready;
   logic [31:0]     out_re, out_im;
   logic [2:0]      out_idx;
   logic            out_last, busy;
   logic [15:0]     frame_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fft8_stream_ctrl #(.CORE_LAT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .core_x_re (core_x_re),
      .core_x_im (core_x_im),
      .core_X_re (core_X_re),
      .core_X_im (core_X_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   // X[k] = sum x[n] * (cos(2pi nk/8) - j sin(2pi nk/8)), Q16.16
   function automatic logic [255:0] dft_part(input logic [255:0] xr,
                                             input logic [255:0] xi,
                                             input bit want_im);
      longint cs[8] = '{65536, 46341, 0, -46341, -65536, -46341, 0, 46341};
      longint sn[8] = '{0, 46341, 65536, 46341, 0, -46341, -65536, -46341};
      logic [255:0] r = '0;
      for (int k = 0; k < 8; k++) begin
         longint ar = 0;
         longint ai = 0;
         for (int n = 0; n < 8; n++) begin
            int     m = (n * k) % 8;
            longint a = longint'($signed(xr[n*32 +: 32]));
            longint b = longint'($signed(xi[n*32 +: 32]));
            ar += (a * cs[m] + b * sn[m]) >>> 16;
            ai += (b * cs[m] - a * sn[m]) >>> 16;
         end
         r[k*32 +: 32] = want_im ? ai[31:0] : ar[31:0];
      end
      return r;
   endfunction

   assign dft_re = dft_part(core_x_re, core_x_im, 1'b0);
   assign dft_im = dft_part(core_x_re, core_x_im, 1'b1);

   always @(posedge clk) begin
      core_X_re <= dft_re;
      core_X_im <= dft_im;
   end

   typedef struct {
      logic [31:0] xr[8];
      logic [31:0] xi[8];
      logic [31:0] er[8];
      logic [31:0] ei[8];
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Sends 8 samples, then checks WAIT refuses input and the latency to out_valid.
   task automatic send_frame(input int v, input bit keep_valid);
      int got = 0;
      int cyc = 0;
      int lat = 0;
      while (got < 8 && cyc < 200) begin
         bit r;
         in_valid = 1'b1;
         in_re    = vecs[v].xr[got];
         in_im    = vecs[v].xi[got];
         r        = in_ready;
         tick();
         if (r) got++;
         cyc++;
      end
      chk("send_done", 64'(got), 64'd8);
      if (!keep_valid) in_valid = 1'b0;
      in_valid = keep_valid ? 1'b1 : 1'b0;
      while (!out_valid && lat < 50) begin
         chk("wait_in_ready", 64'(in_ready), 64'd0);
         chk("wait_busy", 64'(busy), 64'd1);
         tick();
         lat++;
      end
      chk("latency", 64'(lat), 64'd2);
   endtask

   // Collects 8 bins under an out_ready pattern, checking each on every cycle.
   task automatic recv_frame(input int v, input logic [3:0] pat);
      int i = 0;
      int cyc = 0;
      while (i < 8 && cyc < 200) begin
         bit acc;
         chk("out_valid", 64'(out_valid), 64'd1);
         chk("out_idx", 64'(out_idx), 64'(i));
         chk("out_re", 64'(out_re), 64'(vecs[v].er[i]));
         chk("out_im", 64'(out_im), 64'(vecs[v].ei[i]));
         chk("out_last", 64'(out_last), 64'(i == 7));
         chk("unload_in_ready", 64'(in_ready), 64'd0);
         out_ready = pat[cyc % 4];
         acc = out_ready && out_valid;
         tick();
         if (acc) i++;
         cyc++;
      end
      chk("recv_done", 64'(i), 64'd8);
      out_ready = 1'b0;
      chk("post_out_valid", 64'(out_valid), 64'd0);
      chk("post_in_ready", 64'(in_ready), 64'd1);
      chk("post_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k < 8; k++) begin
            vecs[v].xr[k] = ZERO;
            vecs[v].xi[k] = ZERO;
            vecs[v].er[k] = ZERO;
            vecs[v].ei[k] = ZERO;
         end
      end
      vecs[0].xr[0] = ONE;
      for (int k = 0; k < 8; k++) vecs[0].er[k] = ONE;
      for (int k = 0; k < 8; k++) vecs[1].xr[k] = ONE;
      vecs[1].er[0] = 32'h0008_0000;
      vecs[2].xr[1] = ONE;
      vecs[2].er = '{ONE, C, ZERO, NC, NONE, NC, ZERO, C};
      vecs[2].ei = '{ZERO, NC, NONE, NC, ZERO, C, ONE, C};
      vecs[3].xi[0] = ONE;
      for (int k = 0; k < 8; k++) vecs[3].ei[k] = ONE;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_re     = '0;
      in_im     = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_out_idx", 64'(out_idx), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_re", 64'(out_re), 64'd0);
      chk("rst_core_x_re", 64'(core_x_re[63:0]), 64'd0);

      for (int v = 0; v < 4; v++) begin
         send_frame(v, 1'b1);
         recv_frame(v, 4'b1111);
         chk("frame_cnt_table", 64'(frame_cnt), 64'(v + 1));
      end

      // Backpressure: ready pattern 1,0,0,1 per cycle
      send_frame(2, 1'b0);
      recv_frame(2, 4'b1001);
      chk("frame_cnt_bp", 64'(frame_cnt), 64'd5);

      // Reset after 5 of 8 samples, then a clean impulse frame
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_re    = 32'h1234_5678;
         in_im    = 32'h0BAD_F00D;
         tick();
      end
      in_valid = 1'b0;
      do_reset();
      chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("midrst_core_x", 64'(core_x_re[63:0]), 64'd0);
      send_frame(0, 1'b0);
      recv_frame(0, 4'b1111);
      chk("midrst_frame_cnt_after", 64'(frame_cnt), 64'd1);

      // Back-to-back frames with in_valid held high
      do_reset();
      send_frame(2, 1'b1);
      recv_frame(2, 4'b1111);
      send_frame(1, 1'b1);
      recv_frame(1, 4'b1111);
      send_frame(3, 1'b1);
      recv_frame(3, 4'b1111);
      in_valid = 1'b0;
      chk("b2b_frame_cnt", 64'(frame_cnt), 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
